instruction_fetch_unit: RTL
===========================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 64'h0, SHALL be the PC value loaded on reset.
REQ-002 CLK  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-003 ResetL  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 NextPC  input  64  SHALL carry the next-PC value from the next-PC logic.
REQ-005 Advance  input  1  SHALL mean the downstream datapath has consumed the current instruction.
REQ-006 ImemReady  input  1  SHALL mean instruction memory presents valid ImemRData this cycle.
REQ-007 ImemRData  input  32  SHALL carry the instruction word from memory.
REQ-008 ImemReq  output  1  SHALL request a fetch at ImemAddr.
REQ-009 ImemAddr  output  64  SHALL equal CurrentPC at all times.
REQ-010 CurrentPC  output  64  SHALL be the registered PC, fed to the next-PC logic and datapath.
REQ-011 Instruction  output  32  SHALL hold the latched instruction word.
REQ-012 InstrValid  output  1  SHALL mean Instruction corresponds to CurrentPC and awaits Advance.
REQ-013 Fault  output  1  SHALL flag a misaligned NextPC (sticky).

Function
REQ-014 The FSM SHALL have states REQ, VALID, FAULT; ImemReq=1 only in REQ, InstrValid=1 only in VALID, Fault=1 only in FAULT.
REQ-015 REQ: on an edge with ImemReady=1, Instruction<=ImemRData and state->VALID; otherwise stay in REQ, Instruction unchanged.
REQ-016 Fetch latency SHALL be one cycle minimum: ImemReady sampled in the first REQ cycle gives InstrValid=1 the next cycle.
REQ-017 VALID: on an edge with Advance=1, CurrentPC<=NextPC; state->REQ if NextPC[1:0]==2'b00, else state->FAULT.
REQ-018 VALID with Advance=0 SHALL hold CurrentPC, Instruction and InstrValid unchanged indefinitely.
REQ-019 Advance SHALL be ignored in REQ and FAULT; ImemReady SHALL be ignored in VALID and FAULT.
REQ-020 FAULT SHALL be absorbing until reset; CurrentPC holds the misaligned value; no further requests issued.
REQ-021 CurrentPC SHALL only change via reset or REQ-017; no internal increment (NextPC supplies all arithmetic, 64-bit wrap is the supplier's concern).
REQ-022 Back-to-back throughput SHALL be one instruction per two cycles with ImemReady and Advance held high.

Reset
REQ-023 ResetL=0 SHALL immediately force state=REQ, CurrentPC=RESET_PC, Instruction=32'h0, InstrValid=0, Fault=0, ImemReq=1 while ResetL is low.
REQ-024 Reset asserted mid-fetch or in VALID SHALL discard the pending/held instruction; no Advance effect is applied on the edge where ResetL is low.
REQ-025 RESET_PC with bits [1:0] nonzero SHALL NOT cause FAULT; alignment is checked only on NextPC.

Configuration
REQ-026 With macro FETCH_STALL_CNT_EN defined, output StallCount[31:0] SHALL exist, reset to 0, incrementing on each edge in REQ with ImemReady=0, saturating at 32'hFFFF_FFFF.
REQ-027 Without FETCH_STALL_CNT_EN, StallCount and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-028 Reset with RESET_PC=64'h0, ImemReady=1, ImemRData=32'h8B020020 -> cycle 1 InstrValid=1, Instruction=32'h8B020020, CurrentPC=0.
REQ-029 VALID, NextPC=64'h4, Advance=1 -> CurrentPC=64'h4, ImemReq=1, InstrValid=0 next cycle.
REQ-030 REQ with ImemReady=0 for 3 cycles then 1 -> InstrValid rises on 4th edge; StallCount=3 when FETCH_STALL_CNT_EN defined.
REQ-031 VALID, Advance=1, NextPC=64'h102 -> Fault=1, CurrentPC=64'h102, ImemReq=0; further Advance/ImemReady no effect until ResetL=0.
REQ-032 ResetL pulsed low mid-REQ at CurrentPC=64'h40 -> CurrentPC=RESET_PC immediately, InstrValid=0, Fault=0, no clock edge needed.
REQ-033 VALID with Advance=0 for 5 cycles while NextPC toggles -> CurrentPC and Instruction stable, InstrValid=1 throughout.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and memory.
// master: fetch unit (issues requests), slave: instruction memory (returns data).
interface instruction_fetch_unit_if;
    logic        ImemReq;
    logic [63:0] ImemAddr;
    logic        ImemReady;
    logic [31:0] ImemRData;

    modport master (
        output ImemReq,
        output ImemAddr,
        input  ImemReady,
        input  ImemRData
    );

    modport slave (
        input  ImemReq,
        input  ImemAddr,
        output ImemReady,
        output ImemRData
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds the PC, requests the instruction at that PC,
// latches it, and presents it until the datapath advances. A misaligned
// next PC parks the unit in a sticky FAULT state until reset.
// Optional feature: define FETCH_STALL_CNT_EN to add the StallCount output,
// which counts cycles spent waiting on instruction memory.
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        CLK,
    input  logic        ResetL,
    input  logic [63:0] NextPC,
    input  logic        Advance,
    output logic [63:0] CurrentPC,
    output logic [31:0] Instruction,
    output logic        InstrValid,
    output logic        Fault,
`ifdef FETCH_STALL_CNT_EN
    output logic [31:0] StallCount,
`endif
    instruction_fetch_unit_if.master imem
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_VALID = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   pc_load;
    logic   instr_load;
    logic   imem_req;
    logic   instr_valid;
    logic   fault;

    // State register; reset returns to requesting at RESET_PC.
    always_ff @(posedge CLK or negedge ResetL) begin
        if (!ResetL) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode; Advance only matters in VALID,
    // ImemReady only matters in REQ, FAULT is absorbing.
    always_comb begin
        state_next  = state;
        pc_load     = 1'b0;
        instr_load  = 1'b0;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        fault       = 1'b0;
        case (state)
            S_REQ: begin
                imem_req = 1'b1;
                if (imem.ImemReady) begin
                    instr_load = 1'b1;
                    state_next = S_VALID;
                end
            end
            S_VALID: begin
                instr_valid = 1'b1;
                if (Advance) begin
                    pc_load = 1'b1;
                    // Alignment is checked on the incoming PC only, never on RESET_PC.
                    state_next = (NextPC[1:0] == 2'b00) ? S_REQ : S_FAULT;
                end
            end
            S_FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_next = S_REQ;
            end
        endcase
    end

    // PC and instruction registers; the PC only ever takes NextPC, never increments itself.
    always_ff @(posedge CLK or negedge ResetL) begin
        if (!ResetL) begin
            CurrentPC   <= RESET_PC;
            Instruction <= 32'h0;
        end else begin
            if (pc_load) begin
                CurrentPC <= NextPC;
            end
            if (instr_load) begin
                Instruction <= imem.ImemRData;
            end
        end
    end

    assign imem.ImemReq  = imem_req;
    assign imem.ImemAddr = CurrentPC;
    assign InstrValid    = instr_valid;
    assign Fault         = fault;

`ifdef FETCH_STALL_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

    logic stall_cycle;
    assign stall_cycle = (state == S_REQ) && !imem.ImemReady;

    // Memory-wait counter, saturating so it never wraps back to a small value.
    always_ff @(posedge CLK or negedge ResetL) begin
        if (!ResetL) begin
            StallCount <= 32'h0;
        end else if (stall_cycle) begin
            StallCount <= sat_inc(StallCount);
        end
    end
`endif

endmodule
